cluster_accumulator: RTL

Per-frame accumulator for the K-means centroid update, sitting directly upstream of `pixel_divider`. It consumes a stream of pixel components, each tagged with its assigned cluster index, and builds one running component sum and one member count per cluster. At end of frame it presents sums as dividends, counts as divisors and a non-empty-cluster mask as divider enables. It holds them until the divider reports completion, then clears for the next frame.

---
 rtl/kmeans_pkg.sv | 17 +
 rtl/cluster_acc_lane.sv | 61 ++++++
 rtl/cluster_accumulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared K-means constants and the accumulator state encoding.
// The downstream pixel_divider uses the same widths.
package kmeans_pkg;

  localparam int K     = 16;
  localparam int PIX_W = 8;
  localparam int SUM_W = 20;
  localparam int CNT_W = 12;
  localparam int CL_W  = $clog2(K);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } acc_state_e;

endpackage

// File: rtl/cluster_acc_lane.sv
// One cluster lane: running component sum and member count.
// Optional feature macro: CLUSTER_ACC_SATURATE_EN (clamp instead of wrap).
module cluster_acc_lane
  import kmeans_pkg::*;
#(
  parameter int L_PIX_W = PIX_W,
  parameter int L_SUM_W = SUM_W,
  parameter int L_CNT_W = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               add_en_i,
  input  logic [L_PIX_W-1:0] pix_i,
  output logic [L_SUM_W-1:0] sum_o,
  output logic [L_CNT_W-1:0] cnt_o,
  output logic               nonempty_o,
  output logic               ovf_o
);

  logic [L_SUM_W-1:0] sum_q, sum_d;
  logic [L_CNT_W-1:0] cnt_q, cnt_d;
  logic [L_SUM_W:0]   sum_ext;
  logic [L_CNT_W:0]   cnt_ext;

  // Widen by one bit so the carry out of each add is visible.
  assign sum_ext = {1'b0, sum_q} + {{(L_SUM_W + 1 - L_PIX_W){1'b0}}, pix_i};
  assign cnt_ext = {1'b0, cnt_q} + (L_CNT_W + 1)'(1);

  // Next-state for the lane: hold, or add with clamp/wrap on carry.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (add_en_i) begin
`ifdef CLUSTER_ACC_SATURATE_EN
      sum_d = sum_ext[L_SUM_W] ? {L_SUM_W{1'b1}} : sum_ext[L_SUM_W-1:0];
      cnt_d = cnt_ext[L_CNT_W] ? {L_CNT_W{1'b1}} : cnt_ext[L_CNT_W-1:0];
`else
      sum_d = sum_ext[L_SUM_W-1:0];
      cnt_d = cnt_ext[L_CNT_W-1:0];
`endif
    end
  end

  // Lane registers; cleared by reset or by the end-of-frame clear.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o      = sum_q;
  assign cnt_o      = cnt_q;
  assign nonempty_o = |cnt_q;
  assign ovf_o      = add_en_i & (sum_ext[L_SUM_W] | cnt_ext[L_CNT_W]);

endmodule

// File: rtl/cluster_accumulator.sv
// Per-frame K-means centroid accumulator feeding pixel_divider.
// Collects per-cluster sums/counts, presents them to the divider at end of
// frame, waits for completion, then clears for the next frame.
// Optional feature macro: CLUSTER_ACC_SATURATE_EN (lanes clamp instead of wrap).
module cluster_accumulator
  import kmeans_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic [CL_W-1:0]      pix_cluster,
  input  logic                 pix_last,
  output logic [K-1:0]         div_en,
  output logic [K*SUM_W-1:0]   div_dividend,
  output logic [K*CNT_W-1:0]   div_divisor,
  input  logic                 div_all_ready,
  output logic                 frame_done,
  output logic                 overflow
);

  acc_state_e state_q;
  logic       pix_ready_q;
  logic       frame_done_q;
  logic       blank_q;
  logic       overflow_q;

  logic           accept;
  logic           lane_clr;
  logic [K-1:0]   lane_en;
  logic [K-1:0]   mask;
  logic [K-1:0]   lane_ovf;

  assign accept   = pix_valid & pix_ready_q;
  assign lane_clr = (state_q == DONE);

  // Lane array: decode of the cluster tag, sums/counts and flattening.
  // A tag >= K matches no lane, so such a beat is accepted and dropped.
  for (genvar k = 0; k < K; k++) begin : g_lane
    logic [SUM_W-1:0] sum_k;
    logic [CNT_W-1:0] cnt_k;

    assign lane_en[k] = accept && (pix_cluster == CL_W'(k));

    cluster_acc_lane #(
      .L_PIX_W(PIX_W),
      .L_SUM_W(SUM_W),
      .L_CNT_W(CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (lane_clr),
      .add_en_i  (lane_en[k]),
      .pix_i     (pix_data),
      .sum_o     (sum_k),
      .cnt_o     (cnt_k),
      .nonempty_o(mask[k]),
      .ovf_o     (lane_ovf[k])
    );

    assign div_dividend[k*SUM_W +: SUM_W] = sum_k;
    assign div_divisor[k*CNT_W +: CNT_W]  = cnt_k;
  end

  // Frame control: accumulate, hand off to the divider, single-cycle done.
  // The first DIVIDE cycle is a blanking cycle so a stale ready from the
  // previous frame cannot end this one; an empty frame leaves right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      pix_ready_q  <= 1'b1;
      frame_done_q <= 1'b0;
      blank_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (|lane_ovf) overflow_q <= 1'b1;
          if (accept && pix_last) begin
            state_q     <= DIVIDE;
            pix_ready_q <= 1'b0;
            blank_q     <= 1'b1;
          end
        end
        DIVIDE: begin
          blank_q <= 1'b0;
          if ((blank_q && (mask == '0)) || (!blank_q && div_all_ready)) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= ACCUM;
          pix_ready_q <= 1'b1;
          overflow_q  <= 1'b0;
        end
        default: begin
          state_q     <= ACCUM;
          pix_ready_q <= 1'b1;
          blank_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign div_en     = (state_q == DIVIDE) ? mask : '0;

endmodule
